// File: rtl/pc_fetch_control.sv
// pc_fetch_control: fetch/execute sequencer for the 8-bit single-cycle CPU.
// Owns the PC, fetches instruction words over the IMEM busywait handshake,
// holds each word stable while it executes, stalls on data memory, and
// selects the next PC from the decoded JUMP/BRANCH controls and OFFSET.
//
// Ports:
//   CLK            system clock, rising-edge
//   RESET          asynchronous active-low reset
//   IMEM_BUSYWAIT  instruction memory busy (0 = INSTR_IN valid)
//   INSTR_IN       instruction word from instruction memory
//   DMEM_BUSYWAIT  data memory busy, holds the instruction in execute
//   JUMP, BRANCH   decoded control for the executing instruction
//   ZERO           ALU zero flag for the executing instruction
//   OFFSET         signed word offset (instruction bits 23:16)
//   IMEM_READ      instruction memory read request
//   PC             current instruction address (also IMEM address)
//   INSTRUCTION    latched instruction word for decode
//   INSTR_VALID    INSTRUCTION is valid (execute state)
//   COMMIT         one-cycle datapath write enable
//   STALL          fetching, or execute waiting on data memory
//   INSTR_COUNT    retired-instruction counter (wraps)
module pc_fetch_control #(
  parameter int unsigned            PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0]    RESET_PC  = '0,
  parameter int unsigned            CNT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 IMEM_BUSYWAIT,
  input  logic [31:0]          INSTR_IN,
  input  logic                 DMEM_BUSYWAIT,
  input  logic                 JUMP,
  input  logic                 BRANCH,
  input  logic                 ZERO,
  input  logic [7:0]           OFFSET,
  output logic                 IMEM_READ,
  output logic [PC_WIDTH-1:0]  PC,
  output logic [31:0]          INSTRUCTION,
  output logic                 INSTR_VALID,
  output logic                 COMMIT,
  output logic                 STALL,
  output logic [CNT_WIDTH-1:0] INSTR_COUNT
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } state_t;

  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

  state_t                state, next_state;
  logic                  fetch_done;
  logic                  commit;
  logic                  taken;
  logic [PC_WIDTH-1:0]   pc_reg;
  logic [PC_WIDTH-1:0]   pc_plus4;
  logic [PC_WIDTH-1:0]   offset_ext;
  logic [PC_WIDTH-1:0]   next_pc;
  logic [31:0]           instr_reg;
  logic [CNT_WIDTH-1:0]  count_reg;

  // Offset is in words: sign-extend, then scale by 4 by appending two zeros.
  always_comb begin
    offset_ext = {{(PC_WIDTH-8){OFFSET[7]}}, OFFSET};
    taken      = JUMP | (BRANCH & ZERO);
    pc_plus4   = pc_reg + PC_STEP;
    next_pc    = taken ? (pc_plus4 + {offset_ext[PC_WIDTH-3:0], 2'b00}) : pc_plus4;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= S_BOOT;
    end else begin
      state <= next_state;
    end
  end

  // Outputs are pure state decodes except COMMIT/STALL in execute, so an
  // asynchronous reset (state -> S_BOOT) drops them without a clock.
  always_comb begin
    next_state  = state;
    IMEM_READ   = 1'b0;
    INSTR_VALID = 1'b0;
    commit      = 1'b0;
    STALL       = 1'b1;
    fetch_done  = 1'b0;
    case (state)
      S_BOOT: begin
        next_state = S_FETCH;
      end
      S_FETCH: begin
        IMEM_READ = 1'b1;
        if (!IMEM_BUSYWAIT) begin
          fetch_done = 1'b1;
          next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        INSTR_VALID = 1'b1;
        STALL       = DMEM_BUSYWAIT;
        commit      = ~DMEM_BUSYWAIT;
        if (!DMEM_BUSYWAIT) begin
          next_state = S_FETCH;
        end
      end
      default: begin
        next_state = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pc_reg    <= RESET_PC;
      instr_reg <= '0;
      count_reg <= '0;
    end else begin
      if (fetch_done) begin
        instr_reg <= INSTR_IN;
      end
      if (commit) begin
        pc_reg    <= next_pc;
        count_reg <= count_reg + CNT_WIDTH'(1);
      end
    end
  end

  assign COMMIT      = commit;
  assign PC          = pc_reg;
  assign INSTRUCTION = instr_reg;
  assign INSTR_COUNT = count_reg;

endmodule

// File: tb/tb_pc_fetch_control.sv
module tb_pc_fetch_control;

  logic        CLK;
  logic        RESET;
  logic        IMEM_BUSYWAIT;
  logic [31:0] INSTR_IN;
  logic        DMEM_BUSYWAIT;
  logic        JUMP;
  logic        BRANCH;
  logic        ZERO;
  logic [7:0]  OFFSET;

  logic        imem_read;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        commit;
  logic        stall;
  logic [15:0] instr_count;

  logic        imem_read_w;
  logic [31:0] pc_w;
  logic [31:0] instruction_w;
  logic        instr_valid_w;
  logic        commit_w;
  logic        stall_w;
  logic [3:0]  instr_count_w;

  int unsigned n_checks;
  int unsigned n_fail;

  pc_fetch_control dut (
    .CLK(CLK), .RESET(RESET), .IMEM_BUSYWAIT(IMEM_BUSYWAIT), .INSTR_IN(INSTR_IN),
    .DMEM_BUSYWAIT(DMEM_BUSYWAIT), .JUMP(JUMP), .BRANCH(BRANCH), .ZERO(ZERO),
    .OFFSET(OFFSET), .IMEM_READ(imem_read), .PC(pc), .INSTRUCTION(instruction),
    .INSTR_VALID(instr_valid), .COMMIT(commit), .STALL(stall), .INSTR_COUNT(instr_count)
  );

  // Wrap instance: PC starts at the top of the address space, 4-bit counter.
  pc_fetch_control #(
    .PC_WIDTH(32),
    .RESET_PC(32'hFFFF_FFFC),
    .CNT_WIDTH(4)
  ) dut_w (
    .CLK(CLK), .RESET(RESET), .IMEM_BUSYWAIT(IMEM_BUSYWAIT), .INSTR_IN(INSTR_IN),
    .DMEM_BUSYWAIT(DMEM_BUSYWAIT), .JUMP(JUMP), .BRANCH(BRANCH), .ZERO(ZERO),
    .OFFSET(OFFSET), .IMEM_READ(imem_read_w), .PC(pc_w), .INSTRUCTION(instruction_w),
    .INSTR_VALID(instr_valid_w), .COMMIT(commit_w), .STALL(stall_w), .INSTR_COUNT(instr_count_w)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached (actual running, required finished)");
    $fatal(1, "watchdog");
  end

  // Reset for 3 cycles, release at a negedge; next posedge is the boot edge.
  task automatic do_reset();
    RESET         = 1'b0;
    IMEM_BUSYWAIT = 1'b0;
    DMEM_BUSYWAIT = 1'b0;
    INSTR_IN      = '0;
    JUMP          = 1'b0;
    BRANCH        = 1'b0;
    ZERO          = 1'b0;
    OFFSET        = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  // Reset then step past boot: returns at a negedge with the DUT in fetch.
  task automatic reset_to_fetch();
    do_reset();
    @(negedge CLK);
  endtask

  // From a negedge in fetch, run one zero-wait instruction; returns in fetch.
  task automatic run_instr(input logic j, input logic b, input logic z,
                           input logic [7:0] off, input logic [31:0] word);
    INSTR_IN = word;
    @(negedge CLK);
    JUMP   = j;
    BRANCH = b;
    ZERO   = z;
    OFFSET = off;
    @(negedge CLK);
    JUMP   = 1'b0;
    BRANCH = 1'b0;
    ZERO   = 1'b0;
    OFFSET = '0;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    IMEM_BUSYWAIT = 1'b0;
    DMEM_BUSYWAIT = 1'b0;
    INSTR_IN = 32'h1234_5678;
    JUMP = 1'b0; BRANCH = 1'b0; ZERO = 1'b0; OFFSET = '0;
    repeat (3) @(posedge CLK);
    #1;
    n_checks++;
    if (pc !== 32'd0 || instr_count !== 16'd0 || instruction !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_regs: pc=%h cnt=%0d instr=%h required pc=0 cnt=0 instr=0", pc, instr_count, instruction);
    end
    n_checks++;
    if (imem_read !== 1'b0 || instr_valid !== 1'b0 || commit !== 1'b0 || stall !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_outs: rd=%b v=%b c=%b st=%b required 0 0 0 1", imem_read, instr_valid, commit, stall);
    end
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    n_checks++;
    if (imem_read !== 1'b0 || stall !== 1'b1) begin
      n_fail++;
      $display("FAIL boot_cycle: rd=%b st=%b required rd=0 st=1", imem_read, stall);
    end
    @(negedge CLK);
    n_checks++;
    if (imem_read !== 1'b1 || instr_valid !== 1'b0 || pc !== 32'd0 || instr_count !== 16'd0) begin
      n_fail++;
      $display("FAIL first_fetch: rd=%b v=%b pc=%h cnt=%0d required rd=1 v=0 pc=0 cnt=0", imem_read, instr_valid, pc, instr_count);
    end
  endtask

  task automatic test_sequential();
    int unsigned pulses;
    pulses = 0;
    reset_to_fetch();
    for (int unsigned i = 0; i < 4; i++) begin
      n_checks++;
      if (pc !== 32'(4 * i) || imem_read !== 1'b1 || commit !== 1'b0 || stall !== 1'b1) begin
        n_fail++;
        $display("FAIL seq_fetch%0d: pc=%h rd=%b c=%b st=%b required pc=%h rd=1 c=0 st=1", i, pc, imem_read, commit, stall, 32'(4 * i));
      end
      INSTR_IN = 32'hA000_0000 + 32'(i);
      @(negedge CLK);
      if (commit === 1'b1) pulses++;
      n_checks++;
      if (instr_valid !== 1'b1 || instruction !== 32'hA000_0000 + 32'(i) || stall !== 1'b0 || imem_read !== 1'b0) begin
        n_fail++;
        $display("FAIL seq_exec%0d: v=%b instr=%h st=%b rd=%b required v=1 instr=%h st=0 rd=0", i, instr_valid, instruction, stall, imem_read, 32'hA000_0000 + 32'(i));
      end
      INSTR_IN = 32'hFFFF_FFFF;
      @(negedge CLK);
    end
    n_checks++;
    if (pc !== 32'd16 || instr_count !== 16'd4 || pulses != 4) begin
      n_fail++;
      $display("FAIL seq_end: pc=%h cnt=%0d pulses=%0d required pc=10 cnt=4 pulses=4", pc, instr_count, pulses);
    end
  endtask

  task automatic test_branch();
    logic        j [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        b [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic        z [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [7:0]  o [6] = '{8'hFE, 8'h03, 8'h03, 8'h01, 8'h80, 8'h7F};
    logic [31:0] e [6] = '{32'd4, 32'd12, 32'd24, 32'd16, 32'hFFFF_FE0C, 32'd520};
    for (int unsigned k = 0; k < 6; k++) begin
      reset_to_fetch();
      run_instr(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
      run_instr(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
      run_instr(j[k], b[k], z[k], o[k], 32'h5555_0000);
      n_checks++;
      if (pc !== e[k] || instr_count !== 16'd3) begin
        n_fail++;
        $display("FAIL branch%0d: pc=%h cnt=%0d required pc=%h cnt=3", k, pc, instr_count, e[k]);
      end
    end
  endtask

  task automatic test_stall();
    reset_to_fetch();
    run_instr(1'b0, 1'b0, 1'b0, 8'h00, 32'h1111_0000);
    n_checks++;
    if (pc !== 32'd4 || imem_read !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_start: pc=%h rd=%b required pc=4 rd=1", pc, imem_read);
    end
    IMEM_BUSYWAIT = 1'b1;
    INSTR_IN      = 32'hDEAD_BEEF;
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge CLK);
      n_checks++;
      if (imem_read !== 1'b1 || instruction !== 32'h1111_0000 || stall !== 1'b1 || instr_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL imem_wait%0d: rd=%b instr=%h st=%b v=%b required rd=1 instr=11110000 st=1 v=0", i, imem_read, instruction, stall, instr_valid);
      end
    end
    IMEM_BUSYWAIT = 1'b0;
    DMEM_BUSYWAIT = 1'b1;
    @(negedge CLK);
    IMEM_BUSYWAIT = 1'b1;
    INSTR_IN = 32'h0BAD_0BAD;
    JUMP = 1'b1;
    OFFSET = 8'h10;
    n_checks++;
    if (instruction !== 32'hDEAD_BEEF || instr_valid !== 1'b1 || commit !== 1'b0 || stall !== 1'b1 || pc !== 32'd4) begin
      n_fail++;
      $display("FAIL dmem_wait0: instr=%h v=%b c=%b st=%b pc=%h required deadbeef 1 0 1 4", instruction, instr_valid, commit, stall, pc);
    end
    @(negedge CLK);
    n_checks++;
    if (instruction !== 32'hDEAD_BEEF || commit !== 1'b0 || pc !== 32'd4 || instr_count !== 16'd1) begin
      n_fail++;
      $display("FAIL dmem_wait1: instr=%h c=%b pc=%h cnt=%0d required deadbeef 0 4 1", instruction, commit, pc, instr_count);
    end
    DMEM_BUSYWAIT = 1'b0;
    JUMP   = 1'b0;
    OFFSET = 8'h00;
    #1;
    n_checks++;
    if (commit !== 1'b1 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL dmem_release: c=%b st=%b required c=1 st=0", commit, stall);
    end
    @(negedge CLK);
    IMEM_BUSYWAIT = 1'b0;
    n_checks++;
    if (pc !== 32'd8 || commit !== 1'b0 || imem_read !== 1'b1 || instr_count !== 16'd2) begin
      n_fail++;
      $display("FAIL stall_end: pc=%h c=%b rd=%b cnt=%0d required pc=8 c=0 rd=1 cnt=2", pc, commit, imem_read, instr_count);
    end
  endtask

  task automatic test_wrap();
    reset_to_fetch();
    n_checks++;
    if (pc_w !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL wrap_reset_pc: pc=%h required fffffffc", pc_w);
    end
    run_instr(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    n_checks++;
    if (pc_w !== 32'd0 || instr_count_w !== 4'd1) begin
      n_fail++;
      $display("FAIL wrap_pc: pc=%h cnt=%0d required pc=0 cnt=1", pc_w, instr_count_w);
    end
    for (int unsigned i = 0; i < 14; i++) run_instr(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    n_checks++;
    if (instr_count_w !== 4'd15) begin
      n_fail++;
      $display("FAIL cnt_max: cnt=%0d required 15", instr_count_w);
    end
    run_instr(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    n_checks++;
    if (instr_count_w !== 4'd0 || instr_count !== 16'd16 || pc !== 32'd64) begin
      n_fail++;
      $display("FAIL cnt_wrap: cnt_w=%0d cnt=%0d pc=%h required 0 16 40", instr_count_w, instr_count, pc);
    end
  endtask

  task automatic test_async_reset();
    reset_to_fetch();
    run_instr(1'b0, 1'b0, 1'b0, 8'h00, 32'h2222_0000);
    INSTR_IN = 32'h3333_0000;
    DMEM_BUSYWAIT = 1'b1;
    @(negedge CLK);
    #2;
    RESET = 1'b0;
    #1;
    n_checks++;
    if (commit !== 1'b0 || instr_valid !== 1'b0 || imem_read !== 1'b0 || stall !== 1'b1) begin
      n_fail++;
      $display("FAIL async_exec_outs: c=%b v=%b rd=%b st=%b required 0 0 0 1", commit, instr_valid, imem_read, stall);
    end
    n_checks++;
    if (pc !== 32'd0 || instruction !== 32'd0 || instr_count !== 16'd0 || pc_w !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL async_exec_regs: pc=%h instr=%h cnt=%0d pc_w=%h required 0 0 0 fffffffc", pc, instruction, instr_count, pc_w);
    end
    DMEM_BUSYWAIT = 1'b0;
    reset_to_fetch();
    #2;
    RESET = 1'b0;
    #1;
    n_checks++;
    if (imem_read !== 1'b0) begin
      n_fail++;
      $display("FAIL async_fetch: rd=%b required 0", imem_read);
    end
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_sequential();
    test_branch();
    test_stall();
    test_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
